btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Front end for the four Basys3 directional push-buttons, feeding the button-to-mux-select decoder.
- Synchronises, debounces and arbitrates the raw pads so that downstream logic sees clean levels with at most one button asserted, plus a one-cycle press strobe.
- Sits between the top-level pads and the select decoder, in the single system clock domain.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from its stable value before the change is accepted (10 ms at 100 MHz); legal range >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 50000000, cycles a button is held before the first auto-repeat strobe (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat strobes (AUTOREPEAT_EN only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btnU_in  in  1  raw up pad, asynchronous.
- btnD_in  in  1  raw down pad, asynchronous.
- btnR_in  in  1  raw right pad, asynchronous.
- btnL_in  in  1  raw left pad, asynchronous.
- btnU  out  1  clean up level, registered.
- btnD  out  1  clean down level, registered.
- btnR  out  1  clean right level, registered.
- btnL  out  1  clean left level, registered.
- press_pulse  out  1  one-cycle strobe on each accepted press.
- lockout  out  1  high while multi-press lockout is active.

Behaviour:
- Reset (one clk, rst=1): all outputs 0; synchronisers, stable bits and counters 0; FSM to IDLE.
- Per-button path:
  - 2-flop synchroniser, then debounce.
  - The counter clears whenever the synchronised value equals the stable bit.
  - Otherwise the counter increments. On the edge where counter == DEBOUNCE_CYCLES-1 and the values still disagree, the stable bit takes the new value and the counter clears.
  - A single disagreeing glitch restarts qualification.
- Latency: raw change first sampled at edge 0 gives stable updated at edge DEBOUNCE_CYCLES+1. Outputs and press_pulse follow at edge DEBOUNCE_CYCLES+2. Releases follow the same latency.
- Arbitration FSM, states IDLE, HELD, LOCKOUT; the held-button index is 2 bits:
  - IDLE: exactly one stable bit high -> HELD with that index, press_pulse=1 for that cycle. Two or more high -> LOCKOUT, no pulse. None high -> stay.
  - HELD: only the held button's output is high. Other buttons rising are ignored (first wins). When the held button's stable bit falls: if any other stable bit is high -> LOCKOUT, else -> IDLE. The output drops on the same edge as the state change.
  - LOCKOUT: all button outputs 0, lockout=1. When all stable bits are 0 -> IDLE.
- The four button outputs are always one-hot or zero, never multi-hot.
- press_pulse never lasts more than 1 cycle and never asserts in LOCKOUT.
- rst mid-operation: immediate return to the reset state. Buttons still held must fully re-qualify (DEBOUNCE_CYCLES+2 edges after rst deasserts) and produce a fresh pulse.

Optional Feature:
- Macro: BTN_CONDITIONER_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs from entry.
  - press_pulse re-asserts for 1 cycle REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while held.
  - The counter clears on leaving HELD or on rst.
- Undefined: no repeat counter is instantiated; exactly one press_pulse per accepted press.

Decomposition:
- Package btn_pkg holds:
  - FSM state typedef (IDLE/HELD/LOCKOUT).
  - Button index constants BTN_L=0, BTN_R=1, BTN_D=2, BTN_U=3, matching the decoder's bit order {U,D,R,L}.
  - Default debounce and repeat constants.
- Sub-module btn_debounce (synchroniser, counter and stable bit, one bit wide), instantiated four times. The FSM stays in the top level.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- rst=1 for 2 cycles with all raw inputs high -> all outputs 0, lockout=0 throughout; after release, the 4-high condition gives lockout=1 at edge 6.
- btnL_in rises cleanly (sampled edge 0), held 20 cycles -> btnL=1 and press_pulse=1 at edge 6 only. Release sampled at edge 20 -> btnL=0 at edge 26.
- btnR_in toggles every 2 cycles for 12 cycles then settles high (last edge sampled at edge t) -> no output before t+6; btnR=1 at t+6 with exactly one pulse.
- btnU_in and btnD_in rise together -> LOCKOUT, all button outputs 0, no pulse. Both released -> IDLE after 6 edges. A following btnU press gives btnU=1 plus a pulse.
- btnU held, then btnD pressed -> btnU stays 1, btnD 0. Release btnU -> btnU=0, lockout=1 until btnD released.
- With AUTOREPEAT_EN, btnR held 60 cycles -> pulses at accept edge E, E+20, E+28, E+36, E+44, E+52. Without the macro -> pulse at E only.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state encoding, button bit positions and default timing for btn_conditioner.
package btn_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_HELD    = 2'd1;
  localparam state_t S_LOCKOUT = 2'd2;
  // Bit order {U,D,R,L} matches the downstream select decoder.
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_CNT_W           = 20;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;
  function automatic logic [1:0] btn_index(input logic [3:0] v);
    return v[BTN_U] ? 2'(BTN_U) : v[BTN_D] ? 2'(BTN_D) : v[BTN_R] ? 2'(BTN_R) : 2'(BTN_L);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus counter that accepts a change after DEBOUNCE_CYCLES disagreeing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d, agree, done;
  assign agree    = sync_q[1] == stable_q;
  assign done     = !agree && cnt_q == LAST;
  assign cnt_d    = (agree || done) ? '0 : cnt_q + 1'b1;
  assign stable_d = done ? sync_q[1] : stable_q;
  assign stable_o = stable_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounce and one-hot arbitration of the four direction buttons with a press strobe.
// Optional auto-repeat strobes while held are enabled by defining BTN_CONDITIONER_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W = DEF_CNT_W
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btnU_in,
  input  logic btnD_in,
  input  logic btnR_in,
  input  logic btnL_in,
  output logic btnU,
  output logic btnD,
  output logic btnR,
  output logic btnL,
  output logic press_pulse,
  output logic lockout
);
  logic [3:0] raw, stable;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic pulse_q, pulse_d, press_d, one_hot, multi;
  assign raw = {btnU_in, btnD_in, btnR_in, btnL_in};
  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk), .rst(rst), .raw_i(raw[i]), .stable_o(stable[i])
    );
  end
  assign one_hot = stable != 4'd0 && (stable & (stable - 4'd1)) == 4'd0;
  assign multi   = stable != 4'd0 && !one_hot;
  assign press_d = state_q == S_IDLE && one_hot;
  assign idx_d   = press_d ? btn_index(stable) : idx_q;
  // In HELD only the held button's release matters; others pressed meanwhile force a lockout.
  assign state_d = state_q == S_IDLE ? (one_hot ? S_HELD : multi ? S_LOCKOUT : S_IDLE)
                 : state_q == S_HELD ? (stable[idx_q] ? S_HELD : |stable ? S_LOCKOUT : S_IDLE)
                 : (|stable ? S_LOCKOUT : S_IDLE);
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  logic [31:0] rep_q, rep_d;
  logic staying, rep_hit;
  assign staying = state_q == S_HELD && stable[idx_q];
  assign rep_hit = staying && rep_q == 32'(REPEAT_DELAY - 1);
  // After the first repeat the counter rewinds so later hits come every REPEAT_PERIOD.
  assign rep_d   = !staying ? 32'd0 : rep_hit ? 32'(REPEAT_DELAY - REPEAT_PERIOD) : rep_q + 32'd1;
  assign pulse_d = press_d | rep_hit;
  always_ff @(posedge clk) begin
    if (rst) rep_q <= 32'd0;
    else rep_q <= rep_d;
  end
`else
  assign pulse_d = press_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
    end
  end
  assign {btnU, btnD, btnR, btnL} = state_q == S_HELD ? 4'b1 << idx_q : 4'b0;
  assign press_pulse = pulse_q;
  assign lockout     = state_q == S_LOCKOUT;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and randomized checks of btn_conditioner against a behavioural model.
module tb_btn_conditioner;
  localparam int DC = 4;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam int RD = 20;
  localparam int RP = 8;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic u = 1'b1, d = 1'b1, r = 1'b1, l = 1'b1;
  logic btnU, btnD, btnR, btnL, press_pulse, lockout;
  int checks = 0, passed = 0;
  btn_conditioner #(
    .DEBOUNCE_CYCLES(DC), .CNT_W(3)
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk(clk), .rst(rst), .btnU_in(u), .btnD_in(d), .btnR_in(r), .btnL_in(l),
    .btnU(btnU), .btnD(btnD), .btnR(btnR), .btnL(btnL),
    .press_pulse(press_pulse), .lockout(lockout)
  );
  always #5 clk = ~clk;
  // Model: a button is accepted once its last DC synchronised samples all disagree with its stable level.
  logic [3:0] m_st = '0, m_p1 = '0, m_p2 = '0;
  bit hist[4][$];
  int held = -1, rep = 0;
  bit lock = 0, e_pulse = 0, m_ok = 0;
  always @(posedge clk) begin
    int n;
    bit agree_any;
    if (rst) begin
      m_st = '0; m_p1 = '0; m_p2 = '0; held = -1; lock = 0; rep = 0; e_pulse = 0;
      for (int b = 0; b < 4; b++) hist[b].delete();
    end else begin
      e_pulse = 0;
      n = $countones(m_st);
      if (lock) lock = n != 0;
      else if (held < 0) begin
        if (n == 1) begin
          for (int b = 0; b < 4; b++) if (m_st[b]) held = b;
          rep = 0;
          e_pulse = 1;
        end else if (n > 1) lock = 1;
      end else if (!m_st[held]) begin
        held = -1;
        lock = n != 0;
      end else begin
        rep++;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        e_pulse = rep >= RD && (rep - RD) % RP == 0;
`endif
      end
      for (int b = 0; b < 4; b++) begin
        hist[b].push_back(m_p2[b]);
        if (hist[b].size() > DC) void'(hist[b].pop_front());
        agree_any = 0;
        foreach (hist[b][j]) if (hist[b][j] == m_st[b]) agree_any = 1;
        if (hist[b].size() == DC && !agree_any) m_st[b] = m_p2[b];
      end
      m_p2 = m_p1;
      m_p1 = {u, d, r, l};
    end
    m_ok = 1;
  end
  always @(negedge clk) begin
    logic [5:0] got, exp;
    if (m_ok) begin
      exp = {held >= 0 ? 4'(1 << held) : 4'b0, e_pulse, lock};
      got = {btnU, btnD, btnR, btnL, press_pulse, lockout};
      checks++;
      if (got === exp) passed++;
      else $display("FAIL model t=%0t: {U,D,R,L,pulse,lockout} got %b expected %b", $time, got, exp);
    end
  end
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic lit(input string nm, input logic a, input logic e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %b expected %b", nm, a, e);
  endtask
  initial begin
    ticks(1);
    lit("rst_lock_a", lockout, 1'b0);
    lit("rst_btn_a", btnU | btnD | btnR | btnL | press_pulse, 1'b0);
    ticks(1);
    lit("rst_lock_b", lockout, 1'b0);
    rst = 1'b0;
    ticks(6);
    lit("rst_lock_e5", lockout, 1'b0);
    ticks(1);
    lit("rst_lock_e6", lockout, 1'b1);
    {u, d, r, l} = 4'h0;
    ticks(6);
    lit("rel_lock_e5", lockout, 1'b1);
    ticks(1);
    lit("rel_lock_e6", lockout, 1'b0);
    ticks(4);
    l = 1'b1;
    ticks(6);
    lit("L_e5", btnL, 1'b0);
    ticks(1);
    lit("L_e6", btnL, 1'b1);
    lit("L_pulse_e6", press_pulse, 1'b1);
    ticks(1);
    lit("L_pulse_e7", press_pulse, 1'b0);
    ticks(12);
    l = 1'b0;
    ticks(6);
    lit("L_rel_e25", btnL, 1'b1);
    ticks(1);
    lit("L_rel_e26", btnL, 1'b0);
    ticks(4);
    r = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ticks(2);
      r = ~r;
    end
    ticks(6);
    lit("R_bounce_t5", btnR, 1'b0);
    ticks(1);
    lit("R_bounce_t6", btnR, 1'b1);
    lit("R_bounce_pulse", press_pulse, 1'b1);
    r = 1'b0;
    ticks(10);
    {u, d} = 2'b11;
    ticks(7);
    lit("UD_lock", lockout, 1'b1);
    lit("UD_btn", btnU | btnD, 1'b0);
    lit("UD_pulse", press_pulse, 1'b0);
    {u, d} = 2'b00;
    ticks(6);
    lit("UD_rel_e5", lockout, 1'b1);
    ticks(1);
    lit("UD_rel_e6", lockout, 1'b0);
    u = 1'b1;
    ticks(7);
    lit("U_after_lock", btnU, 1'b1);
    lit("U_after_pulse", press_pulse, 1'b1);
    d = 1'b1;
    ticks(10);
    lit("U_first_wins", btnU, 1'b1);
    lit("D_ignored", btnD, 1'b0);
    u = 1'b0;
    ticks(7);
    lit("U_rel_btn", btnU, 1'b0);
    lit("U_rel_lock", lockout, 1'b1);
    d = 1'b0;
    ticks(7);
    lit("D_rel_lock", lockout, 1'b0);
    ticks(4);
    r = 1'b1;
    ticks(7);
    lit("rep_E", press_pulse, 1'b1);
    ticks(20);
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    lit("rep_E20", press_pulse, 1'b1);
`else
    lit("rep_E20", press_pulse, 1'b0);
`endif
    ticks(40);
    r = 1'b0;
    ticks(10);
    for (int c = 0; c < 6000; c++) begin
      int span;
      span = c < 3000 ? 12 : 60;
      rst = $urandom_range(0, 399) == 0;
      if ($urandom_range(0, span - 1) == 0) u = ~u;
      if ($urandom_range(0, span - 1) == 0) d = ~d;
      if ($urandom_range(0, span - 1) == 0) r = ~r;
      if ($urandom_range(0, span - 1) == 0) l = ~l;
      ticks(1);
    end
    rst = 1'b0;
    ticks(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
